// File: rtl/bus_arbiter_pkg.sv
// Shared definitions for the internal data-bus arbiter and the bus mux that
// consumes its grant vector.
package bus_arbiter_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_OWN  = 1'b1
  } state_t;

  localparam int DEF_COUNT    = 4;
  localparam int DEF_HOLD_MAX = 16;
  localparam int BUS_WIDTH    = 8;

  // Hold counter must reach HOLD_MAX; with no limit a 1-bit saturating counter suffices.
  function automatic int hold_cnt_w(input int hold_max);
    return (hold_max == 0) ? 1 : $clog2(hold_max + 1);
  endfunction

endpackage

// File: rtl/bus_arbiter_rr_pick.sv
// Combinational round-robin pick: first eligible source at or after ptr, with wrap.
module rr_pick #(
  parameter  int N  = 4,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  eligible,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  onehot,
  output logic [IW-1:0] idx,
  output logic          any
);

  logic [2*N-1:0] dbl;
  logic [N-1:0]   rot;
  logic [IW:0]    off;
  logic [IW:0]    sum;

  // Rotate so ptr lands at bit 0, encode lowest set bit, then rotate the index back.
  assign dbl = {eligible, eligible};
  assign rot = N'(dbl >> ptr);
  assign any = |eligible;

  always_comb begin
    off = '0;
    for (int j = N - 1; j >= 0; j--) begin
      if (rot[j]) off = (IW+1)'(j);
    end
    sum = {1'b0, ptr} + off;
    if (sum >= (IW+1)'(N)) sum = sum - (IW+1)'(N);
    idx    = sum[IW-1:0];
    onehot = any ? (N'(1) << idx) : '0;
  end

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin owner of the internal 8-bit data bus: registered one-hot grant,
// bounded hold time, forced dead cycle between owners.
module bus_arbiter
  import bus_arbiter_pkg::*;
#(
  parameter  int COUNT    = DEF_COUNT,
  parameter  int HOLD_MAX = DEF_HOLD_MAX,
  localparam int IDW      = $clog2(COUNT)
) (
  input  logic             clk_25mhz,
  input  logic             reset,
  input  logic [COUNT-1:0] req,
  output logic [COUNT-1:0] grant,
  output logic [IDW-1:0]   grant_id,
  output logic             grant_valid,
  output logic             expired
);

  localparam int HCW = hold_cnt_w(HOLD_MAX);

  state_t           state, state_n;
  logic [IDW-1:0]   ptr, ptr_n;
  logic [HCW-1:0]   hold_cnt, hold_n;
  logic [COUNT-1:0] lockout, lockout_n;
  logic [COUNT-1:0] grant_n;
  logic [IDW-1:0]   grant_id_n;
  logic             expired_n;

  logic [COUNT-1:0] eligible;
  logic [COUNT-1:0] pick_onehot;
  logic [IDW-1:0]   pick_idx;
  logic             pick_any;
  logic             owner_req;
  logic             at_limit;
  logic [IDW-1:0]   next_ptr;

  assign eligible  = req & ~lockout;
  assign owner_req = req[grant_id];
  assign at_limit  = (HOLD_MAX != 0) && (hold_cnt == HCW'(HOLD_MAX));
  assign next_ptr  = (grant_id == IDW'(COUNT - 1)) ? '0 : grant_id + 1'b1;

  rr_pick #(.N(COUNT)) u_pick (
    .eligible (eligible),
    .ptr      (ptr),
    .onehot   (pick_onehot),
    .idx      (pick_idx),
    .any      (pick_any)
  );

  always_comb begin
    state_n    = state;
    ptr_n      = ptr;
    hold_n     = hold_cnt;
    lockout_n  = lockout & req;   // dropping a request for one cycle clears its lockout
    grant_n    = grant;
    grant_id_n = grant_id;
    expired_n  = 1'b0;
    case (state)
      ST_IDLE: begin
        grant_n = '0;
        if (pick_any) begin
          grant_n    = pick_onehot;
          grant_id_n = pick_idx;
          hold_n     = HCW'(1);
          state_n    = ST_OWN;
        end
      end
      ST_OWN: begin
        if (!owner_req || at_limit) begin
          // Release always passes through IDLE, which gives the turnaround cycle.
          grant_n = '0;
          state_n = ST_IDLE;
          ptr_n   = next_ptr;
          if (owner_req) begin
            expired_n           = 1'b1;
            lockout_n[grant_id] = 1'b1;
          end
        end else if (hold_cnt != '1) begin
          hold_n = hold_cnt + 1'b1;
        end
      end
      default: begin
        grant_n = '0;
        state_n = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_25mhz) begin
    if (reset) begin
      state       <= ST_IDLE;
      ptr         <= '0;
      hold_cnt    <= '0;
      lockout     <= '0;
      grant       <= '0;
      grant_id    <= '0;
      grant_valid <= 1'b0;
      expired     <= 1'b0;
    end else begin
      state       <= state_n;
      ptr         <= ptr_n;
      hold_cnt    <= hold_n;
      lockout     <= lockout_n;
      grant       <= grant_n;
      grant_id    <= grant_id_n;
      grant_valid <= |grant_n;
      expired     <= expired_n;
    end
  end

endmodule

// File: tb/tb_bus_arbiter.sv
// Scoreboard bench for bus_arbiter: directed ownerships are queued as expected
// (grant, id, length, expired) records and checked when each ownership ends.
module tb_bus_arbiter;

  localparam int HOLD = 4;

  typedef struct packed {
    logic [3:0] g;
    logic [1:0] id;
    logic [7:0] len;
    logic       exp;
  } own_t;

  logic       clk_25mhz = 1'b0;
  logic       reset     = 1'b1;
  logic [3:0] req       = '0;
  logic [3:0] grant;
  logic [1:0] grant_id;
  logic       grant_valid;
  logic       expired;

  int   errors = 0;
  int   checks = 0;
  bit   sb_on  = 1'b1;
  own_t exp_q[$];

  bus_arbiter #(.COUNT(4), .HOLD_MAX(HOLD)) dut (
    .clk_25mhz   (clk_25mhz),
    .reset       (reset),
    .req         (req),
    .grant       (grant),
    .grant_id    (grant_id),
    .grant_valid (grant_valid),
    .expired     (expired)
  );

  always #20 clk_25mhz = ~clk_25mhz;

  task automatic tick();
    @(posedge clk_25mhz);
    #1;
  endtask

  task automatic drive(input logic [3:0] v, input int n);
    req = v;
    repeat (n) tick();
  endtask

  task automatic push(input logic [3:0] g, input int id, input int len, input bit e);
    own_t t;
    t.g = g; t.id = 2'(id); t.len = 8'(len); t.exp = e;
    exp_q.push_back(t);
  endtask

  task automatic chk(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, want);
    end
  endtask

  // Monitor: per-cycle invariants plus scoreboard pop at each end of ownership.
  initial begin
    logic       prev_gv;
    logic [3:0] prev_g;
    logic [3:0] cur_g;
    logic [1:0] cur_id;
    int         cur_len;
    own_t       e;
    prev_gv = 1'b0; prev_g = '0; cur_g = '0; cur_id = '0; cur_len = 0;
    forever begin
      @(negedge clk_25mhz);
      chk("valid_eq_or", int'(grant_valid), int'(|grant));
      if (grant_valid) chk("grant_eq_id", int'(grant), int'(4'b0001 << grant_id));
      if (prev_g != 0 && grant != 0) chk("no_adjacent_owner", int'(grant), int'(prev_g));
      if (expired) chk("expired_on_release_only", int'(prev_gv && !grant_valid), 1);
      if (grant_valid && !prev_gv) begin
        cur_g = grant; cur_id = grant_id; cur_len = 1;
      end else if (grant_valid) begin
        cur_len++;
      end else if (prev_gv) begin
        if (sb_on) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_ownership", int'(cur_g), 0);
          end else begin
            e = exp_q.pop_front();
            chk("own_grant",   int'(cur_g),   int'(e.g));
            chk("own_id",      int'(cur_id),  int'(e.id));
            chk("own_len",     cur_len,       int'(e.len));
            chk("own_expired", int'(expired), int'(e.exp));
          end
        end else begin
          checks++;
          if (cur_len > HOLD) begin
            errors++;
            $display("FAIL hold_limit: got %0d cycles expected at most %0d", cur_len, HOLD);
          end
        end
      end
      prev_gv = grant_valid;
      prev_g  = grant;
    end
  end

  initial begin
    int cyc;
    int n;
    logic [3:0] v;

    // Reset state
    drive(4'b0000, 2);
    chk("rst_grant",   int'(grant),       0);
    chk("rst_id",      int'(grant_id),    0);
    chk("rst_valid",   int'(grant_valid), 0);
    chk("rst_expired", int'(expired),     0);
    reset = 1'b0;

    // 1: single request, one-edge latency
    push(4'b0100, 2, 3, 1'b0);
    drive(4'b0100, 1);
    chk("t1_latency_grant", int'(grant), int'(4'b0100));
    chk("t1_latency_id",    int'(grant_id), 2);
    drive(4'b0100, 2);
    drive(4'b0000, 2);

    reset = 1'b1;
    drive(4'b0000, 1);
    reset = 1'b0;

    // 2: round robin 0,1,2,3,0 with all requesting; owner drops after 3 cycles
    for (int k = 0; k < 5; k++) begin
      int o;
      o = k % 4;
      push(4'(1 << o), o, 3, 1'b0);
      drive(4'b1111, 3);
      drive(4'b1111 & ~4'(1 << o), 1);
    end
    drive(4'b0000, 2);

    // 3: forced release at HOLD, lockout until request drops
    push(4'b0001, 0, 4, 1'b1);
    drive(4'b0001, 9);
    drive(4'b0000, 1);
    push(4'b0001, 0, 3, 1'b0);
    drive(4'b0001, 3);
    drive(4'b0000, 2);

    // 4: request drops exactly at the limit -> normal release, immediate regrant
    push(4'b0001, 0, 4, 1'b0);
    drive(4'b0001, 4);
    drive(4'b0000, 1);
    push(4'b0001, 0, 2, 1'b0);
    drive(4'b0001, 2);
    drive(4'b0000, 2);

    // Move ptr to 2 so the post-reset pick below depends on ptr returning to 0
    push(4'b0010, 1, 2, 1'b0);
    drive(4'b0010, 2);
    drive(4'b0000, 2);

    // 5: reset while source 3 owns the bus
    push(4'b1000, 3, 3, 1'b0);
    drive(4'b1000, 3);
    reset = 1'b1;
    drive(4'b1000, 1);
    chk("t5_reset_grant",   int'(grant),   0);
    chk("t5_reset_expired", int'(expired), 0);
    reset = 1'b0;
    push(4'b0010, 1, 2, 1'b0);
    drive(4'b1010, 2);
    drive(4'b0000, 3);
    chk("queue_drained", exp_q.size(), 0);

    // 6: random request levels held for random spans; invariants only
    sb_on = 1'b0;
    cyc = 0;
    while (cyc < 10000) begin
      v = 4'($urandom_range(0, 15));
      n = $urandom_range(1, 8);
      drive(v, n);
      cyc += n;
    end
    drive(4'b0000, 3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
